// File: rtl/arc4_crack_ctrl_if.sv
// Controller-side bus to the arc4 core and the plaintext RAM read port.
// master = crack controller, slave = arc4 core / plaintext memory mux.
interface arc4_crack_ctrl_if #(
  parameter int KEY_W = 24
);
  logic [KEY_W-1:0] a4_key;
  logic             a4_en;
  logic             a4_rdy;
  logic             scan_active;
  logic [7:0]       pt_addr;
  logic [7:0]       pt_rddata;

  modport master (output a4_key, a4_en, scan_active, pt_addr,
                  input  a4_rdy, pt_rddata);
  modport slave  (input  a4_key, a4_en, scan_active, pt_addr,
                  output a4_rdy, pt_rddata);
endinterface

// File: rtl/arc4_crack_ctrl.sv
// ARC4 key-search controller: sweeps keys, runs arc4 per key, accepts the first printable plaintext.
// Optional macro ARC4_CRACK_STOP_EN adds stop_i for sibling-core cancellation.
module arc4_crack_ctrl #(
  parameter int               KEY_W      = 24,
  parameter int               KEY_STRIDE = 1,
  parameter logic [KEY_W-1:0] KEY_MAX    = {KEY_W{1'b1}},
  parameter logic [7:0]       LO_CHAR    = 8'h20,
  parameter logic [7:0]       HI_CHAR    = 8'h7E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic             rdy_o,
  input  logic [KEY_W-1:0] key_start_i,
  output logic             done_o,
  output logic             found_o,
  output logic [KEY_W-1:0] key_found_o,
`ifdef ARC4_CRACK_STOP_EN
  input  logic             stop_i,
`endif
  arc4_crack_ctrl_if.master a4
);

  typedef enum logic [3:0] {
    S_IDLE, S_RANGE_CHK, S_START, S_ARM, S_WAIT_A4,
    S_RD_LEN, S_LEN, S_RD_BYTE, S_CHECK, S_NEXT, S_DONE
  } state_e;

  localparam logic [KEY_W:0] KEY_MAX_X = {1'b0, KEY_MAX};
  localparam logic [KEY_W:0] STRIDE_X  = (KEY_W+1)'(KEY_STRIDE);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_cur_q, key_cur_d;
  logic [KEY_W-1:0] key_found_q, key_found_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       idx_q, idx_d;
  logic             found_q, found_d;
  logic             a4_en_q, a4_en_d;

  // One extra bit so a carry out of the key width still reads as "past KEY_MAX".
  logic [KEY_W:0]   key_nxt;
  logic             byte_ok;

  assign key_nxt = {1'b0, key_cur_q} + STRIDE_X;
  assign byte_ok = (a4.pt_rddata >= LO_CHAR) && (a4.pt_rddata <= HI_CHAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      key_cur_q   <= '0;
      key_found_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      found_q     <= 1'b0;
      a4_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_cur_q   <= key_cur_d;
      key_found_q <= key_found_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      found_q     <= found_d;
      a4_en_q     <= a4_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_cur_d   = key_cur_q;
    key_found_d = key_found_q;
    len_d       = len_q;
    idx_d       = idx_q;
    found_d     = found_q;
    a4_en_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (en_i) begin
          key_cur_d = key_start_i;
          found_d   = 1'b0;
          state_d   = S_RANGE_CHK;
        end
      end
      S_RANGE_CHK: begin
        if ({1'b0, key_cur_q} > KEY_MAX_X) begin
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (a4.a4_rdy) begin
          a4_en_d = 1'b1;
          state_d = S_ARM;
        end
`ifdef ARC4_CRACK_STOP_EN
        if (stop_i) begin
          a4_en_d = 1'b0;
          found_d = 1'b0;
          state_d = S_DONE;
        end
`endif
      end
      // arc4 samples a4_en at the end of ARM and drops rdy before WAIT_A4 looks at it.
      S_ARM: state_d = S_WAIT_A4;
      S_WAIT_A4: begin
        if (a4.a4_rdy) begin
          idx_d   = '0;
          state_d = S_RD_LEN;
        end
      end
      S_RD_LEN: state_d = S_LEN;
      S_LEN: begin
        len_d = a4.pt_rddata;
        if (a4.pt_rddata == 8'd0) begin
          found_d     = 1'b1;
          key_found_d = key_cur_q;
          state_d     = S_DONE;
        end else begin
          idx_d   = 8'd1;
          state_d = S_RD_BYTE;
        end
      end
      S_RD_BYTE: state_d = S_CHECK;
      S_CHECK: begin
        if (!byte_ok) begin
          state_d = S_NEXT;
        end else if (idx_q == len_q) begin
          found_d     = 1'b1;
          key_found_d = key_cur_q;
          state_d     = S_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD_BYTE;
        end
      end
      S_NEXT: begin
        if (key_nxt > KEY_MAX_X) begin
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          key_cur_d = key_nxt[KEY_W-1:0];
          state_d   = S_START;
        end
`ifdef ARC4_CRACK_STOP_EN
        if (stop_i) begin
          key_cur_d = key_cur_q;
          found_d   = 1'b0;
          state_d   = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output comes straight from a register or a decode of state_q.
  assign rdy_o          = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done_o         = (state_q == S_DONE);
  assign found_o        = found_q;
  assign key_found_o    = key_found_q;
  assign a4.a4_key      = key_cur_q;
  assign a4.a4_en       = a4_en_q;
  assign a4.pt_addr     = idx_q;
  assign a4.scan_active = (state_q == S_RD_LEN) || (state_q == S_LEN) ||
                          (state_q == S_RD_BYTE) || (state_q == S_CHECK);

endmodule

// File: tb/tb_arc4_crack_ctrl.sv
// Bench for arc4_crack_ctrl: three parameterisations, table vectors, directed corner
// sequences and randomized messages checked against a key-sweep reference model.
module tb_arc4_crack_ctrl;
  localparam int M_HI = 0, M_SWEEP = 1, M_NONE = 2, M_FIXED = 3, M_RAND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int          gmode  = M_NONE;
  int unsigned gseed  = 0;
  longint      gstart = 0;
  logic [7:0]  fmsg [4];

  typedef struct {
    int         inst;
    longint     start;
    int         mode;
    logic [7:0] m0, m1, m2, m3;
    bit         ef;
    longint     ekf;
    int         ep;
    int         es;
  } vec_t;

  arc4_crack_ctrl_if #(.KEY_W(24)) ifa ();
  arc4_crack_ctrl_if #(.KEY_W(4))  ifb ();
  arc4_crack_ctrl_if #(.KEY_W(5))  ifc ();

  logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [23:0] kst_a = '0;
  logic [3:0]  kst_b = '0;
  logic [4:0]  kst_c = '0;
  logic        rdy_a, rdy_b, rdy_c, done_a, done_b, done_c, found_a, found_b, found_c;
  logic [23:0] kf_a;
  logic [3:0]  kf_b;
  logic [4:0]  kf_c;
`ifdef ARC4_CRACK_STOP_EN
  logic        stop_a = 1'b0;
`endif

  arc4_crack_ctrl #(.KEY_W(24)) ua (
    .clk(clk), .rst(rst), .en_i(en_a), .rdy_o(rdy_a), .key_start_i(kst_a),
    .done_o(done_a), .found_o(found_a), .key_found_o(kf_a),
`ifdef ARC4_CRACK_STOP_EN
    .stop_i(stop_a),
`endif
    .a4(ifa.master));

  arc4_crack_ctrl #(.KEY_W(4), .KEY_STRIDE(4), .KEY_MAX(4'd15)) ub (
    .clk(clk), .rst(rst), .en_i(en_b), .rdy_o(rdy_b), .key_start_i(kst_b),
    .done_o(done_b), .found_o(found_b), .key_found_o(kf_b),
`ifdef ARC4_CRACK_STOP_EN
    .stop_i(1'b0),
`endif
    .a4(ifb.master));

  arc4_crack_ctrl #(.KEY_W(5), .KEY_STRIDE(4), .KEY_MAX(5'd15)) uc (
    .clk(clk), .rst(rst), .en_i(en_c), .rdy_o(rdy_c), .key_start_i(kst_c),
    .done_o(done_c), .found_o(found_c), .key_found_o(kf_c),
`ifdef ARC4_CRACK_STOP_EN
    .stop_i(1'b0),
`endif
    .a4(ifc.master));

  function automatic int unsigned hsh(input longint key, input int idx);
    int unsigned h;
    h = (32'(key) * 32'h9E3779B1) ^ gseed ^ (32'(idx) * 32'h85EBCA6B);
    h = h ^ (h >> 13);
    h = h * 32'hC2B2AE35;
    return h ^ (h >> 16);
  endfunction

  // Plaintext byte at address idx that arc4 would leave for key (idx 0 is the length).
  function automatic logic [7:0] mbyte(input longint key, input int idx);
    int unsigned h;
    logic [7:0] bad [5];
    bad = '{8'h1F, 8'h7F, 8'h00, 8'h80, 8'hFF};
    case (gmode)
      M_HI: begin
        if (key == 64'h33C) return (idx == 0) ? 8'd2 : (idx == 1) ? 8'h48 : (idx == 2) ? 8'h69 : 8'h00;
        return (idx == 0) ? 8'd1 : 8'h07;
      end
      M_SWEEP: begin
        if (key == 64'd5) return (idx == 0) ? 8'd2 : (idx == 1) ? 8'h48 : 8'h69;
        return (idx == 0) ? 8'd2 : (idx == 1) ? 8'h07 : 8'h41;
      end
      M_FIXED: return (idx < 4) ? fmsg[idx] : 8'h00;
      M_RAND: begin
        if (key >= gstart + 12) return (idx == 0) ? 8'd2 : 8'h41;
        h = hsh(key, idx);
        if (idx == 0) return 8'(h % 4);
        if (h[1:0] == 2'd0) return bad[int'(h[4:2]) % 5];
        return 8'(32'h20 + (h >> 8) % 95);
      end
      default: return (idx == 0) ? 8'd1 : 8'h07;
    endcase
  endfunction

  // arc4 core + plaintext RAM stand-ins, plus pulse/scan-cycle monitors per instance.
  int pa = 0, sa = 0, da = 0, pb = 0, sb = 0, db = 0, pc = 0, sc = 0, dc = 0;
  int busy_a = 0, busy_b = 0, busy_c = 0;
  longint lk_a = 0, lk_b = 0, lk_c = 0;
  logic ea_q = 1'b0, eb_q = 1'b0, ec_q = 1'b0, hold_a = 1'b0;

  assign ifa.a4_rdy = (busy_a == 0) && !hold_a;
  assign ifb.a4_rdy = (busy_b == 0);
  assign ifc.a4_rdy = (busy_c == 0);

  always @(posedge clk) begin
    if (rst) busy_a <= 0;
    else if (ifa.a4_en) begin busy_a <= 3; lk_a <= longint'(ifa.a4_key); end
    else if (busy_a != 0) busy_a <= busy_a - 1;
    ifa.pt_rddata <= mbyte(lk_a, int'(ifa.pt_addr));
    if (ifa.a4_en) pa <= pa + 1;
    if (ifa.scan_active) sa <= sa + 1;
    if (ifa.a4_en && ea_q) da <= da + 1;
    ea_q <= ifa.a4_en;
  end

  always @(posedge clk) begin
    if (rst) busy_b <= 0;
    else if (ifb.a4_en) begin busy_b <= 3; lk_b <= longint'(ifb.a4_key); end
    else if (busy_b != 0) busy_b <= busy_b - 1;
    ifb.pt_rddata <= mbyte(lk_b, int'(ifb.pt_addr));
    if (ifb.a4_en) pb <= pb + 1;
    if (ifb.scan_active) sb <= sb + 1;
    if (ifb.a4_en && eb_q) db <= db + 1;
    eb_q <= ifb.a4_en;
  end

  always @(posedge clk) begin
    if (rst) busy_c <= 0;
    else if (ifc.a4_en) begin busy_c <= 3; lk_c <= longint'(ifc.a4_key); end
    else if (busy_c != 0) busy_c <= busy_c - 1;
    ifc.pt_rddata <= mbyte(lk_c, int'(ifc.pt_addr));
    if (ifc.a4_en) pc <= pc + 1;
    if (ifc.scan_active) sc <= sc + 1;
    if (ifc.a4_en && ec_q) dc <= dc + 1;
    ec_q <= ifc.a4_en;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic peek(input int inst, output bit dn, output bit f, output longint kf,
                      output int p, output int s, output int d, output bit r);
    case (inst)
      0: begin dn = done_a; f = found_a; kf = longint'(kf_a); p = pa; s = sa; d = da; r = rdy_a; end
      1: begin dn = done_b; f = found_b; kf = longint'(kf_b); p = pb; s = sb; d = db; r = rdy_b; end
      default: begin dn = done_c; f = found_c; kf = longint'(kf_c); p = pc; s = sc; d = dc; r = rdy_c; end
    endcase
  endtask

  task automatic kick(input int inst, input longint start);
    @(negedge clk);
    case (inst)
      0: begin kst_a = start[23:0]; en_a = 1'b1; end
      1: begin kst_b = start[3:0];  en_b = 1'b1; end
      default: begin kst_c = start[4:0]; en_c = 1'b1; end
    endcase
    @(negedge clk);
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
  endtask

  task automatic wait_done(input int inst, input string tag);
    bit dn, f, r; longint kf; int p, s, d, got;
    got = 0;
    for (int c = 0; c < 4000; c++) begin
      peek(inst, dn, f, kf, p, s, d, r);
      if (dn) begin got = 1; break; end
      @(negedge clk);
    end
    chk({tag, " done"}, got, 1);
  endtask

  task automatic apply(input vec_t v, input string tag);
    bit dn, f, r; longint kf; int p0, s0, d0, p, s, d;
    gmode = v.mode;
    fmsg  = '{v.m0, v.m1, v.m2, v.m3};
    peek(v.inst, dn, f, kf, p0, s0, d0, r);
    kick(v.inst, v.start);
    wait_done(v.inst, tag);
    peek(v.inst, dn, f, kf, p, s, d, r);
    chk({tag, " found"}, f, v.ef);
    if (v.ef) chk({tag, " key_found"}, kf, v.ekf);
    chk({tag, " a4_en pulses"}, p - p0, v.ep);
    chk({tag, " scan cycles"}, s - s0, v.es);
    chk({tag, " a4_en width"}, d - d0, 0);
  endtask

  // Reference: walk the key range by stride, read len then bytes until the first bad one.
  task automatic model(input longint start, input longint kmax, input longint stride,
                       output bit f, output longint kf, output int p, output int s);
    longint k; int len; bit ok; logic [7:0] b;
    k = start; f = 0; kf = 0; p = 0; s = 0;
    while (k <= kmax && !f) begin
      p++; s += 2;
      len = int'(mbyte(k, 0));
      ok = 1;
      for (int i = 1; i <= len; i++) begin
        s += 2;
        b = mbyte(k, i);
        if (b < 8'h20 || b > 8'h7E) begin ok = 0; break; end
      end
      if (ok) begin f = 1; kf = k; end
      else k += stride;
    end
  endtask

  initial begin
    vec_t vt [12];
    vec_t v;
    bit dn, f, r, seen; longint kf; int p0, s0, d0, p, s, d, inst;
    longint st;

    vt[0]  = '{0, 64'h33C, M_HI,    8'd0, 8'h00, 8'h00, 8'h00, 1'b1, 64'h33C, 1, 6};
    vt[1]  = '{0, 64'd0,   M_SWEEP, 8'd0, 8'h00, 8'h00, 8'h00, 1'b1, 64'd5,   6, 26};
    vt[2]  = '{1, 64'd13,  M_NONE,  8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 64'd0,   1, 4};
    vt[3]  = '{1, 64'd1,   M_NONE,  8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 64'd0,   4, 16};
    vt[4]  = '{2, 64'd16,  M_NONE,  8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 64'd0,   0, 0};
    vt[5]  = '{2, 64'd13,  M_NONE,  8'd0, 8'h00, 8'h00, 8'h00, 1'b0, 64'd0,   1, 4};
    vt[6]  = '{0, 64'd7,   M_FIXED, 8'd3, 8'h20, 8'h7E, 8'h41, 1'b1, 64'd7,   1, 8};
    vt[7]  = '{1, 64'd13,  M_FIXED, 8'd1, 8'h7F, 8'h00, 8'h00, 1'b0, 64'd0,   1, 4};
    vt[8]  = '{1, 64'd13,  M_FIXED, 8'd1, 8'h1F, 8'h00, 8'h00, 1'b0, 64'd0,   1, 4};
    vt[9]  = '{0, 64'd9,   M_FIXED, 8'd0, 8'h41, 8'h00, 8'h00, 1'b1, 64'd9,   1, 2};
    vt[10] = '{1, 64'd12,  M_FIXED, 8'd1, 8'h7E, 8'h00, 8'h00, 1'b1, 64'd12,  1, 4};
    vt[11] = '{2, 64'd15,  M_FIXED, 8'd1, 8'h20, 8'h00, 8'h00, 1'b1, 64'd15,  1, 4};

    repeat (3) @(negedge clk);
    chk("rst rdy", rdy_a, 1);
    chk("rst done", done_a, 0);
    chk("rst found", found_a, 0);
    chk("rst key_found", kf_a, 0);
    chk("rst a4_key", ifa.a4_key, 0);
    chk("rst a4_en", ifa.a4_en, 0);
    chk("rst scan_active", ifa.scan_active, 0);
    chk("rst pt_addr", ifa.pt_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("v%0d", i));

    // a4_rdy held low: START must wait, and en while busy is ignored.
    gmode = M_HI; hold_a = 1'b1;
    peek(0, dn, f, kf, p0, s0, d0, r);
    kick(0, 64'h33C);
    repeat (4) @(negedge clk);
    peek(0, dn, f, kf, p, s, d, r);
    chk("hold no a4_en", p - p0, 0);
    chk("hold rdy", r, 0);
    kst_a = 24'd0; en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0; hold_a = 1'b0;
    wait_done(0, "hold");
    peek(0, dn, f, kf, p, s, d, r);
    chk("hold found", f, 1);
    chk("hold key_found", kf, 64'h33C);
    chk("hold a4_en pulses", p - p0, 1);

    // Reset in WAIT_A4 aborts at once; a fresh start then behaves normally.
    gmode = M_SWEEP;
    kick(0, 64'd0);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (ifa.a4_en) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("mid a4_en seen", seen, 1);
    @(negedge clk);
    chk("mid rdy busy", rdy_a, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst rdy", rdy_a, 1);
    chk("mid rst done", done_a, 0);
    chk("mid rst a4_en", ifa.a4_en, 0);
    chk("mid rst scan", ifa.scan_active, 0);
    chk("mid rst found", found_a, 0);
    rst = 1'b0;
    apply(vt[1], "restart");

`ifdef ARC4_CRACK_STOP_EN
    gmode = M_SWEEP;
    peek(0, dn, f, kf, p0, s0, d0, r);
    kick(0, 64'd0);
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      peek(0, dn, f, kf, p, s, d, r);
      if (p - p0 == 3 && ifa.scan_active) seen = 1;
      if (seen && !ifa.scan_active) begin stop_a = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    stop_a = 1'b0;
    wait_done(0, "stop");
    peek(0, dn, f, kf, p, s, d, r);
    chk("stop found", f, 0);
    chk("stop a4_en pulses", p - p0, 3);
`endif

    for (int i = 0; i < 16; i++) begin
      gseed = $urandom;
      gmode = M_RAND;
      inst  = i % 2;
      st    = (inst == 0) ? longint'($urandom_range(0, 32'hFFFFFF)) : longint'($urandom_range(0, 15));
      gstart = st;
      if (inst == 0) model(st, 64'hFFFFFF, 1, f, kf, p, s);
      else           model(st, 64'd15,     4, f, kf, p, s);
      v = '{inst, st, M_RAND, 8'd0, 8'h00, 8'h00, 8'h00, f, kf, p, s};
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
